// File: rtl/cache_controller_if.sv
// cache_controller_if: CPU request/response, cache-array and memory signals of the cache controller.
interface cache_controller_if #(
  parameter int ADDRESS_SIZE           = 32,
  parameter int BLOCK_SIZE             = 32,
  parameter int NUM_OF_BLOCKS_PER_LINE = 4,
  parameter int NUM_OF_CACHE_LINES     = 4
) ();
  localparam int OFF  = $clog2(NUM_OF_BLOCKS_PER_LINE);
  localparam int IDX  = $clog2(NUM_OF_CACHE_LINES);
  localparam int TAG  = ADDRESS_SIZE - OFF - IDX;
  localparam int LINE = BLOCK_SIZE * NUM_OF_BLOCKS_PER_LINE;
  logic                    cpu_req_valid;
  logic                    cpu_req_write;
  logic [ADDRESS_SIZE-1:0] cpu_addr;
  logic [BLOCK_SIZE-1:0]   cpu_wdata;
  logic                    cpu_req_ready;
  logic                    cpu_resp_valid;
  logic [BLOCK_SIZE-1:0]   cpu_rdata;
  logic                    cache_read;
  logic                    cache_write;
  logic [ADDRESS_SIZE-1:0] cache_address;
  logic [BLOCK_SIZE-1:0]   cache_data_i;
  logic                    cache_hit;
  logic                    cache_miss;
  logic [BLOCK_SIZE-1:0]   cache_data_o;
  logic                    cache_victim_valid;
  logic                    cache_victim_dirty;
  logic [TAG-1:0]          cache_victim_tag;
  logic [LINE-1:0]         cache_line_rdata;
  logic                    cache_fill;
  logic                    cache_fill_dirty;
  logic [LINE-1:0]         cache_line_wdata;
  logic                    mem_req;
  logic                    mem_we;
  logic [ADDRESS_SIZE-1:0] mem_addr;
  logic [LINE-1:0]         mem_wdata;
  logic [LINE-1:0]         mem_rdata;
  logic                    mem_ack;
  modport master (
    input  cpu_req_valid, cpu_req_write, cpu_addr, cpu_wdata,
    output cpu_req_ready, cpu_resp_valid, cpu_rdata,
    output cache_read, cache_write, cache_address, cache_data_i,
    input  cache_hit, cache_miss, cache_data_o,
    input  cache_victim_valid, cache_victim_dirty, cache_victim_tag, cache_line_rdata,
    output cache_fill, cache_fill_dirty, cache_line_wdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );
  modport slave (
    output cpu_req_valid, cpu_req_write, cpu_addr, cpu_wdata,
    input  cpu_req_ready, cpu_resp_valid, cpu_rdata,
    input  cache_read, cache_write, cache_address, cache_data_i,
    output cache_hit, cache_miss, cache_data_o,
    output cache_victim_valid, cache_victim_dirty, cache_victim_tag, cache_line_rdata,
    input  cache_fill, cache_fill_dirty, cache_line_wdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/cache_controller.sv
// cache_controller: blocking direct-mapped cache controller sequencing lookup,
// dirty-victim write-back, line refill/install and a one-cycle CPU response.
module cache_controller #(
  parameter int ADDRESS_SIZE           = 32,
  parameter int BLOCK_SIZE             = 32,
  parameter int NUM_OF_BLOCKS_PER_LINE = 4,
  parameter int NUM_OF_CACHE_LINES     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  cache_controller_if.master bus,
  output logic [15:0]        o_hit_count,
  output logic [15:0]        o_miss_count
);
  localparam int OFF  = $clog2(NUM_OF_BLOCKS_PER_LINE);
  localparam int IDX  = $clog2(NUM_OF_CACHE_LINES);
  localparam int TAG  = ADDRESS_SIZE - OFF - IDX;
  localparam int LINE = BLOCK_SIZE * NUM_OF_BLOCKS_PER_LINE;
  typedef enum logic [2:0] {IDLE, LOOKUP, CHECK, WRITEBACK, FILL, INSTALL, RESPOND} state_t;
  state_t                  r_state, w_next;
  logic                    r_write;
  logic [ADDRESS_SIZE-1:0] r_addr;
  logic [BLOCK_SIZE-1:0]   r_wdata, r_rdata;
  logic [TAG-1:0]          r_vtag;
  logic [LINE-1:0]         r_vline, r_line, w_fill;
  logic [15:0]             r_hit_count, r_miss_count;
  logic [OFF-1:0]          w_off;
  logic [IDX-1:0]          w_idx;
  logic [TAG-1:0]          w_tag;
  logic [BLOCK_SIZE-1:0]   w_word;
  logic                    w_hit, w_unused;
  assign w_off    = r_addr[OFF-1:0];
  assign w_idx    = r_addr[OFF+IDX-1:OFF];
  assign w_tag    = r_addr[ADDRESS_SIZE-1:OFF+IDX];
  assign w_word   = bus.cache_line_rdata[w_off*BLOCK_SIZE +: BLOCK_SIZE];
  // a valid indexed line with our tag is a hit even when the array reports miss (e.g. dirty)
  assign w_hit    = bus.cache_hit | (bus.cache_victim_valid & (bus.cache_victim_tag == w_tag));
  assign w_unused = bus.cache_miss;
  for (genvar k = 0; k < NUM_OF_BLOCKS_PER_LINE; k++) begin : g_fill
    assign w_fill[k*BLOCK_SIZE +: BLOCK_SIZE] = (r_write && w_off == OFF'(k)) ? r_wdata
                                              : bus.mem_rdata[k*BLOCK_SIZE +: BLOCK_SIZE];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = bus.cpu_req_valid ? LOOKUP : IDLE;
      LOOKUP:    w_next = CHECK;
      CHECK:     w_next = w_hit ? RESPOND
                        : (bus.cache_victim_valid && bus.cache_victim_dirty) ? WRITEBACK : FILL;
      WRITEBACK: w_next = bus.mem_ack ? FILL : WRITEBACK;
      FILL:      w_next = bus.mem_ack ? INSTALL : FILL;
      INSTALL:   w_next = RESPOND;
      default:   w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_vtag       <= '0;
      r_vline      <= '0;
      r_line       <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (r_state == IDLE && bus.cpu_req_valid) begin
        r_addr  <= bus.cpu_addr;
        r_write <= bus.cpu_req_write;
        r_wdata <= bus.cpu_wdata;
      end
      if (r_state == CHECK) begin
        r_vtag  <= bus.cache_victim_tag;
        r_vline <= bus.cache_line_rdata;
        if (w_hit && !r_write) r_rdata <= bus.cache_hit ? bus.cache_data_o : w_word;
        if (w_hit && r_hit_count != 16'hFFFF) r_hit_count <= r_hit_count + 16'd1;
        if (!w_hit && r_miss_count != 16'hFFFF) r_miss_count <= r_miss_count + 16'd1;
      end
      if (r_state == FILL && bus.mem_ack) r_line <= w_fill;
      if (r_state == INSTALL && !r_write) r_rdata <= r_line[w_off*BLOCK_SIZE +: BLOCK_SIZE];
    end
  end
  assign bus.cpu_req_ready    = rst_n && r_state == IDLE;
  assign bus.cpu_resp_valid   = r_state == RESPOND;
  assign bus.cpu_rdata        = r_rdata;
  assign bus.cache_read       = r_state == LOOKUP;
  assign bus.cache_write      = r_state == CHECK && w_hit && r_write;
  assign bus.cache_address    = r_addr;
  assign bus.cache_data_i     = r_wdata;
  assign bus.cache_fill       = r_state == INSTALL;
  assign bus.cache_fill_dirty = r_state == INSTALL && r_write;
  assign bus.cache_line_wdata = r_line;
  // victim tag/line are latched in CHECK so the write-back stays stable until ack
  assign bus.mem_req          = r_state == WRITEBACK || r_state == FILL;
  assign bus.mem_we           = r_state == WRITEBACK;
  assign bus.mem_addr         = r_state == WRITEBACK ? {r_vtag, w_idx, {OFF{1'b0}}}
                              : r_state == FILL ? {w_tag, w_idx, {OFF{1'b0}}} : '0;
  assign bus.mem_wdata        = r_state == WRITEBACK ? r_vline : '0;
  assign o_hit_count          = r_hit_count;
  assign o_miss_count         = r_miss_count;
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: directed scoreboard bench for cache_controller (4-word and 2-word line variants).
module tb_cache_controller;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] hit_count, miss_count, hit2, miss2;
  int          n_vec = 0, n_err = 0, cyc_n = 0, t0 = 0;
  typedef struct {bit rd; logic [31:0] d;} exp_t;
  exp_t        sb[$];
  localparam logic [127:0] L1 = 128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000;
  localparam logic [127:0] VL = 128'hD1D1D1D3_D1D1D1D2_D1D1D1D1_D1D1D1D0;
  localparam logic [127:0] ML = 128'h77770003_77770002_77770001_77770000;
  localparam logic [127:0] M2 = 128'h99990003_99990002_99990001_99990000;
  localparam logic [127:0] M2W = 128'h99990003_A5A5A5A5_99990001_99990000;

  cache_controller_if bus ();
  cache_controller_if #(.NUM_OF_BLOCKS_PER_LINE(2)) bus2 ();
  cache_controller dut (.clk(clk), .rst_n(rst_n), .bus(bus), .o_hit_count(hit_count), .o_miss_count(miss_count));
  cache_controller #(.NUM_OF_BLOCKS_PER_LINE(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2), .o_hit_count(hit2), .o_miss_count(miss2));

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic set_cache(bit hit, bit vv, bit vd, logic [27:0] vtag, logic [127:0] line, logic [31:0] dout);
    bus.cache_hit = hit;
    bus.cache_miss = !hit;
    bus.cache_victim_valid = vv;
    bus.cache_victim_dirty = vd;
    bus.cache_victim_tag = vtag;
    bus.cache_line_rdata = line;
    bus.cache_data_o = dout;
  endtask

  task automatic send(bit we, logic [31:0] a, logic [31:0] d, logic [31:0] e);
    int t = 0;
    while (!bus.cpu_req_ready && t < 20) begin cyc(); t++; end
    chk("cpu_req_ready", bus.cpu_req_ready, 1'b1);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_write = we;
    bus.cpu_addr = a;
    bus.cpu_wdata = d;
    sb.push_back('{rd: !we, d: e});
    t0 = cyc_n;
    cyc();
    bus.cpu_req_valid = 1'b0;
    chk("lookup_read_addr", {bus.cache_read, bus.cache_address}, {1'b1, a});
  endtask

  task automatic wait_resp(int lat);
    exp_t e;
    while (!bus.cpu_resp_valid && cyc_n - t0 < 60) cyc();
    chk("resp_valid", bus.cpu_resp_valid, 1'b1);
    chk("latency", cyc_n - t0, lat);
    e = sb.pop_front();
    if (e.rd) chk("cpu_rdata", bus.cpu_rdata, e.d);
    cyc();
    chk("resp_one_cycle", {bus.cpu_resp_valid, bus.cpu_req_ready}, 2'b01);
  endtask

  task automatic mem_txn(bit we, logic [31:0] a, logic [127:0] wd, int dly, logic [127:0] rd);
    int t = 0;
    while (!bus.mem_req && t < 30) begin cyc(); t++; end
    chk("mem_req_we_addr", {bus.mem_req, bus.mem_we, bus.mem_addr}, {1'b1, we, a});
    if (we) chk("mem_wdata", bus.mem_wdata, wd);
    repeat (dly) cyc();
    chk("mem_hold", {bus.mem_req, bus.mem_we, bus.mem_addr}, {1'b1, we, a});
    bus.mem_rdata = rd;
    bus.mem_ack = 1'b1;
    cyc();
    bus.mem_ack = 1'b0;
  endtask

  task automatic chk_install(logic [127:0] line, bit dirty);
    chk("install_strobes", {bus.cache_fill, bus.cache_fill_dirty, bus.mem_req, bus.cpu_resp_valid}, {1'b1, dirty, 2'b00});
    chk("install_line", bus.cache_line_wdata, line);
  endtask

  task automatic v2(bit we, logic [31:0] a, logic [31:0] d, logic [63:0] mline, logic [63:0] eline, logic [31:0] erd);
    exp_t e;
    int t = 0;
    bus2.cpu_req_valid = 1'b1;
    bus2.cpu_req_write = we;
    bus2.cpu_addr = a;
    bus2.cpu_wdata = d;
    sb.push_back('{rd: !we, d: erd});
    cyc();
    bus2.cpu_req_valid = 1'b0;
    while (!bus2.mem_req && t < 20) begin cyc(); t++; end
    chk("v2_mem_req", {bus2.mem_req, bus2.mem_we, bus2.mem_addr}, {2'b10, a & 32'hFFFF_FFFE});
    bus2.mem_rdata = mline;
    bus2.mem_ack = 1'b1;
    cyc();
    bus2.mem_ack = 1'b0;
    chk("v2_install", {bus2.cache_fill, bus2.cache_fill_dirty, bus2.cache_line_wdata}, {1'b1, we, eline});
    cyc();
    e = sb.pop_front();
    chk("v2_resp", {bus2.cpu_resp_valid, e.rd ? bus2.cpu_rdata : 32'h0}, {1'b1, e.d & {32{e.rd}}});
    cyc();
  endtask

  initial begin
    int t;
    logic acc;
    bus.cpu_req_valid = 0; bus.cpu_req_write = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.mem_rdata = 0; bus.mem_ack = 0;
    set_cache(0, 0, 0, 0, 0, 0);
    bus2.cpu_req_valid = 0; bus2.cpu_req_write = 0; bus2.cpu_addr = 0; bus2.cpu_wdata = 0;
    bus2.cache_hit = 0; bus2.cache_miss = 0; bus2.cache_data_o = 0; bus2.cache_victim_valid = 0;
    bus2.cache_victim_dirty = 0; bus2.cache_victim_tag = 0; bus2.cache_line_rdata = 0;
    bus2.mem_rdata = 0; bus2.mem_ack = 0;
    #1;
    chk("reset_outputs", {bus.cpu_req_ready, bus.cpu_resp_valid, bus.cache_read, bus.cache_write, bus.cache_fill,
                          bus.mem_req, bus.mem_addr, hit_count, miss_count}, 0);
    #12 rst_n = 1'b1;
    #1 chk("ready_after_reset", bus.cpu_req_ready, 1'b1);
    cyc();
    // read hit
    set_cache(1, 0, 0, 0, 0, 32'hDEADBEEF);
    send(0, 32'h0000_0104, 0, 32'hDEADBEEF);
    cyc();
    chk("read_one_cycle", bus.cache_read, 1'b0);
    wait_resp(3);
    chk("hit_count_1", hit_count, 16'd1);
    // clean read miss with a stray ack before the memory request
    set_cache(0, 0, 0, 0, 0, 0);
    send(0, 32'h0000_0034, 0, 32'hC0DE0000);
    bus.mem_ack = 1'b1;
    cyc();
    bus.mem_ack = 1'b0;
    chk("no_mem_req_in_check", bus.mem_req, 1'b0);
    mem_txn(0, 32'h0000_0034, 0, 4, L1);
    chk_install(L1, 0);
    wait_resp(9);
    chk("miss_count_1", miss_count, 16'd1);
    // dirty read miss: write-back then refill
    set_cache(0, 1, 1, 28'h5, VL, 0);
    send(0, 32'h0000_0126, 0, 32'h77770002);
    mem_txn(1, 32'h0000_0054, VL, 2, 0);
    mem_txn(0, 32'h0000_0124, 0, 1, ML);
    chk_install(ML, 0);
    wait_resp(9);
    chk("miss_count_2", miss_count, 16'd2);
    // write miss merges the word into the fetched line
    set_cache(0, 0, 0, 0, 0, 0);
    send(1, 32'h0000_0206, 32'hA5A5A5A5, 0);
    mem_txn(0, 32'h0000_0204, 0, 0, M2);
    chk_install(M2W, 1);
    wait_resp(5);
    // write hit
    set_cache(1, 0, 0, 0, 0, 0);
    send(1, 32'h0000_0300, 32'h12345678, 0);
    cyc();
    chk("write_hit", {bus.cache_write, bus.cache_read, bus.mem_req, bus.cache_data_i, bus.cache_address},
                     {3'b100, 32'h12345678, 32'h0000_0300});
    wait_resp(3);
    // dirty line with matching tag is a hit served from the line data
    set_cache(0, 1, 1, 28'h12, VL, 0);
    send(0, 32'h0000_0127, 0, 32'hD1D1D1D3);
    wait_resp(3);
    chk("counts_after_hits", {hit_count, miss_count}, {16'd3, 16'd3});
    // reset in the middle of a refill
    set_cache(0, 0, 0, 0, 0, 0);
    send(0, 32'h0000_0400, 0, 0);
    t = 0;
    while (!bus.mem_req && t < 20) begin cyc(); t++; end
    chk("fill_mem_req", {bus.mem_req, bus.mem_we}, 2'b10);
    rst_n = 1'b0;
    #1;
    chk("async_reset", {bus.mem_req, bus.cpu_req_ready, bus.cache_fill, bus.cpu_resp_valid, hit_count, miss_count}, 0);
    sb.delete();
    cyc();
    rst_n = 1'b1;
    acc = 1'b0;
    repeat (4) begin
      cyc();
      acc = acc | bus.cpu_resp_valid | bus.cache_fill | bus.mem_req;
    end
    chk("no_resume_after_reset", {acc, bus.cpu_req_ready}, 2'b01);
    set_cache(1, 0, 0, 0, 0, 32'hFEEDF00D);
    send(0, 32'h0000_0500, 0, 32'hFEEDF00D);
    wait_resp(3);
    chk("counts_after_reset", {hit_count, miss_count}, {16'd1, 16'd0});
    // saturation of the hit counter
    force dut.r_hit_count = 16'hFFFE;
    #1;
    release dut.r_hit_count;
    send(0, 32'h0000_0504, 0, 32'hFEEDF00D);
    wait_resp(3);
    chk("hit_count_max", hit_count, 16'hFFFF);
    send(0, 32'h0000_0508, 0, 32'hFEEDF00D);
    wait_resp(3);
    chk("hit_count_saturated", hit_count, 16'hFFFF);
    // two-word line variant: 1-bit offset
    v2(0, 32'h0000_0013, 0, 64'hBBBBBBBB_AAAAAAAA, 64'hBBBBBBBB_AAAAAAAA, 32'hBBBBBBBB);
    v2(1, 32'h0000_0010, 32'h00000055, 64'hCCCCCCCC_EEEEEEEE, 64'hCCCCCCCC_00000055, 0);
    chk("v2_miss_count", miss2, 16'd2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d miscompares=%0d", n_vec, n_err);
    $fatal(1, "watchdog");
  end
endmodule
